// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin pick helper for the adder arbiter.
// rr_pick works on a fixed-width vector so any requester count up to RR_MAX can use it.
package adder_arb_pkg;

   localparam int DEF_W    = 8;
   localparam int DEF_NREQ = 4;
   localparam int RR_MAX   = 32;
   localparam int RR_IDX   = $clog2(RR_MAX);

   typedef logic [$clog2(DEF_NREQ)-1:0] id_t;

   typedef struct packed {
      logic [DEF_W-1:0] sum;
      logic             carry;
      id_t              id;
   } rsp_t;

   // One-hot grant for the first set bit of valid at or above ptr, wrapping modulo n.
   function automatic logic [RR_MAX-1:0] rr_pick(
      input logic [RR_MAX-1:0] valid,
      input int unsigned       ptr,
      input int unsigned       n
   );
      logic [RR_MAX-1:0] grant;
      logic              found;
      int unsigned       idx;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx[RR_IDX-1:0]]) begin
               grant[idx[RR_IDX-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/adder.sv
// Shared combinational W-bit adder; sum wraps modulo 2^W.
module adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   output logic [W-1:0] sum
);

   assign sum = a_in + b_in;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter feeding one shared adder through a two-stage pipeline.
// S1 holds the granted operands, S2 holds the tagged result driving rsp_*.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0][W-1:0]  req_a,
   input  logic [NREQ-1:0][W-1:0]  req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [W-1:0]            rsp_sum,
   output logic                    rsp_carry,
   output logic [$clog2(NREQ)-1:0] rsp_id
);

   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0]  ptr_q, ptr_d;
   logic            s1_valid_q, s1_valid_d;
   logic [W-1:0]    s1_a_q, s1_a_d;
   logic [W-1:0]    s1_b_q, s1_b_d;
   logic [IDW-1:0]  s1_id_q, s1_id_d;
   logic            s2_valid_q, s2_valid_d;
   logic [W-1:0]    s2_sum_q, s2_sum_d;
   logic            s2_carry_q, s2_carry_d;
   logic [IDW-1:0]  s2_id_q, s2_id_d;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            adv1, adv2;
   logic [W-1:0]    add_sum;
   logic            add_carry;

   // Grant sees only req_valid and ptr; rsp_ready reaches req_ready solely through adv1.
   assign grant = NREQ'(rr_pick(RR_MAX'(req_valid), 32'(ptr_q), NREQ));
   assign adv2  = !s2_valid_q || rsp_ready;
   assign adv1  = !s1_valid_q || adv2;

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) grant_id = IDW'(i);
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = grant[gi] & adv1 & reset;
      end
   endgenerate

   adder #(.W(W)) u_adder (
      .a_in (s1_a_q),
      .b_in (s1_b_q),
      .sum  (add_sum)
   );

   // Carry recovered from the operand MSBs and the wrapped sum MSB.
   assign add_carry = (s1_a_q[W-1] & s1_b_q[W-1]) |
                      ((s1_a_q[W-1] ^ s1_b_q[W-1]) & ~add_sum[W-1]);

   always_comb begin
      ptr_d      = ptr_q;
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_id_d    = s1_id_q;
      s2_valid_d = s2_valid_q;
      s2_sum_d   = s2_sum_q;
      s2_carry_d = s2_carry_q;
      s2_id_d    = s2_id_q;
      if (|req_ready) begin
         ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
      end
      if (adv1) begin
         s1_valid_d = |req_valid;
         s1_a_d     = req_a[grant_id];
         s1_b_d     = req_b[grant_id];
         s1_id_d    = grant_id;
      end
      if (adv2) begin
         s2_valid_d = s1_valid_q;
         s2_sum_d   = add_sum;
         s2_carry_d = add_carry;
         s2_id_d    = s1_id_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_id_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_sum_q   <= '0;
         s2_carry_q <= 1'b0;
         s2_id_q    <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_id_q    <= s1_id_d;
         s2_valid_q <= s2_valid_d;
         s2_sum_q   <= s2_sum_d;
         s2_carry_q <= s2_carry_d;
         s2_id_q    <= s2_id_d;
      end
   end

   assign rsp_valid = s2_valid_q;
   assign rsp_sum   = s2_sum_q;
   assign rsp_carry = s2_carry_q;
   assign rsp_id    = s2_id_q;

endmodule
